mod5_check_tx: RTL and testbench
================================

// Module: mod5_check_tx
// PURPOSE
//  Parallel-to-serial transmitter feeding the serial mod-5 checker (MSB-first, 1 bit/clk).
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first.
//  Then appends a 3-bit check suffix C (MSB-first) that makes the whole frame divisible by 5.
//  Whole frame value = N*8 + C. A downstream checker reset at frame start must flag
//  divisible on the frame's final bit.
// PARAMETERS
//  WIDTH  8  payload bits per frame; legal range 1..32
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous active-low reset
//  data_i          in   WIDTH  payload word N, sampled on the accept cycle
//  valid_i         in   1      data_i valid
//  ready_o         out  1      block can accept a word this cycle
//  serial_o        out  1      serial bit, MSB-first; 0 whenever serial_valid_o=0
//  serial_valid_o  out  1      serial_o carries a frame bit this cycle
//  last_o          out  1      asserted with the final (LSB) check bit of a frame
// BEHAVIOUR
//  Reset:
//   - Async assert: state=IDLE, shift reg=0, bit counter=0, remainder r=0.
//   - Outputs during reset: serial_o=0, serial_valid_o=0, last_o=0, ready_o=1.
//  Accept:
//   - A word is accepted on any rising edge where valid_i & ready_o.
//  FSM IDLE -> DATA -> CHECK:
//   - IDLE: ready_o=1, serial_valid_o=0. Accept -> load data_i, cnt=WIDTH-1, r=0, go DATA.
//   - DATA: serial_valid_o=1, serial_o=shreg[MSB].
//     Each cycle: r <= (2r + serial_o) mod 5, shift left, cnt--.
//     After the bit with cnt=0 -> go CHECK. The check word C is computed from final r, cnt=2.
//   - CHECK: serial_valid_o=1, serial_o=C[cnt], cnt-- each cycle.
//     The cnt=0 cycle is the last bit: last_o=1, ready_o=1.
//     Exit from the last bit: accept that cycle -> DATA (back-to-back), else -> IDLE.
//  Check word: C = (5 - (3r mod 5)) mod 5, with r = N mod 5.
//   - Map r->C: 0->0, 1->2, 2->4, 3->1, 4->3.
//   - The mapping is a 5-entry case on r. No multiplier or divider.
//  Remainder register:
//   - r is 3 bits and always holds 0..4.
//   - Any illegal value is treated as 0 (default case).
//  Timing:
//   - First bit (N MSB) appears the cycle after accept.
//   - Frame length is WIDTH+3 cycles. Throughput is one frame per WIDTH+3 cycles with valid_i held.
//  Idle/busy:
//   - ready_o=0 for every DATA cycle and every CHECK cycle except the last bit.
//   - valid_i while ready_o=0 is ignored; data_i is not sampled.
//   - A pending valid_i is not lost; the upstream holds it per handshake.
//   - serial_valid_o has no gaps inside a frame.
//  Reset mid-frame:
//   - The frame is aborted immediately.
//   - No last_o pulse; no residual bits after rst_n deasserts; returns to IDLE.
//  Back-to-back frames:
//   - Accept on a last_o cycle: the next cycle carries the new N MSB.
//   - serial_valid_o stays 1 across the boundary.
//   - r restarts at 0 for the new frame.
// TESTING
//  1. WIDTH=8, N=8'h01 -> stream 0000_0001_010 (value 10); last_o on the 11th bit only.
//  2. N=8'h07 (r=2) -> C=3'b100, stream value 60.
//     N=8'hFF (r=0) -> C=3'b000, value 2040. Checker flags divisible at last_o.
//  3. Sweep N=0..255 through checker model -> the frame's final bit reports divisible.
//     No earlier-than-expected mismatch in per-bit remainder vs reference model.
//  4. valid_i held high with N=8'h03 then 8'h04 -> serial_valid_o continuous for 22 cycles.
//     ready_o high only on the 2 last_o cycles.
//  5. valid_i pulsed during DATA -> ignored, ready_o=0, stream unchanged.
//  6. rst_n low at bit 5 of a frame -> serial_valid_o=0 and last_o=0 at once.
//     ready_o=1; the next frame starts cleanly with r=0.

Source files
------------

// File: rtl/mod5_check_tx.sv
// mod5_check_tx: serialises a WIDTH-bit word MSB-first and appends a 3-bit suffix making the frame divisible by 5
module mod5_check_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic             last_o
);
  localparam int CW = WIDTH > 4 ? $clog2(WIDTH) : 2;
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [2:0] r, r_l, r_nx, chk;
  logic [3:0] sum;
  logic accept;
  always_comb begin
    case (r)
      3'd1:    chk = 3'd2;
      3'd2:    chk = 3'd4;
      3'd3:    chk = 3'd1;
      3'd4:    chk = 3'd3;
      default: chk = 3'd0;
    endcase
  end
  assign r_l = r > 3'd4 ? 3'd0 : r;
  assign sum = {r_l, shreg[WIDTH-1]};
  assign r_nx = sum >= 4'd5 ? 3'(sum - 4'd5) : sum[2:0];
  assign serial_valid_o = state != IDLE;
  assign last_o = state == CHECK && cnt == '0;
  assign ready_o = state == IDLE || last_o;
  assign serial_o = state == DATA ? shreg[WIDTH-1] : state == CHECK ? chk[cnt[1:0]] : 1'b0;
  assign accept = valid_i & ready_o;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? DATA : IDLE;
      DATA:    state_nx = cnt == '0 ? CHECK : DATA;
      CHECK:   state_nx = cnt == '0 ? (accept ? DATA : IDLE) : CHECK;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      r     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        shreg <= data_i;
        cnt   <= CW'(WIDTH - 1);
        r     <= '0;
      end else if (state == DATA) begin
        r     <= r_nx;
        shreg <= shreg << 1;
        cnt   <= cnt == '0 ? CW'(2) : cnt - 1'b1;
      end else if (state == CHECK) begin
        cnt   <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mod5_check_tx.sv
// tb_mod5_check_tx: bit-queue reference model plus frame-level mod-5 checker for mod5_check_tx
module tb_mod5_check_tx;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] data_i = '0;
  logic valid_i = 1'b0;
  logic ready_o, serial_o, serial_valid_o, last_o;
  int n_cmp = 0;
  int n_err = 0;
  bit q[$];
  int rem, fval, last_val, sv_cnt, rdy_cnt;
  bit fstart = 1'b1;
  bit acc;
  mod5_check_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .serial_o(serial_o), .serial_valid_o(serial_valid_o), .last_o(last_o)
  );
  always #5 clk = ~clk;
  function automatic int check_word(int n);
    return (5 - (3 * (n % 5)) % 5) % 5;
  endfunction
  task automatic push_frame(int n);
    int c;
    c = check_word(n);
    for (int i = W - 1; i >= 0; i--) q.push_back(n[i]);
    for (int i = 2; i >= 0; i--) q.push_back(c[i]);
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    chk("serial_valid", serial_valid_o, q.size() > 0);
    chk("serial", serial_o, q.size() > 0 ? q[0] : 1'b0);
    chk("last", last_o, q.size() == 1);
    chk("ready", ready_o, q.size() <= 1);
    if (serial_valid_o) begin
      if (fstart) begin
        rem = 0;
        fval = 0;
      end
      fstart = 1'b0;
      rem = (2 * rem + int'(serial_o)) % 5;
      fval = fval * 2 + int'(serial_o);
      if (last_o) begin
        chk("div5_at_last", rem, 0);
        last_val = fval;
        fstart = 1'b1;
      end
    end else fstart = 1'b1;
    sv_cnt += int'(serial_valid_o);
    rdy_cnt += int'(ready_o);
    acc = valid_i && q.size() <= 1;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) push_frame(int'(data_i));
    @(negedge clk);
  endtask
  task automatic reset_outputs(string tag);
    chk({tag, "_valid"}, serial_valid_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_serial"}, serial_o, 0);
    chk({tag, "_ready"}, ready_o, 1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    fstart = 1'b1;
    reset_outputs("rst_now");
    @(negedge clk);
    reset_outputs("rst_hold");
    rst_n = 1'b1;
  endtask
  task automatic single(int n, int exp_val);
    data_i = W'(n);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (W + 4) step();
    chk($sformatf("frame_val_%0h", n), last_val, exp_val);
  endtask
  initial begin
    #1;
    reset_outputs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    single(8'h01, 10);
    single(8'h07, 60);
    single(8'hFF, 2040);
    for (int n = 0; n < 256; n++) begin
      int k;
      k = 0;
      data_i = W'(n);
      valid_i = 1'b1;
      do begin
        step();
        k++;
      end while (!acc && k < 20);
      if (!acc) chk("sweep_accept_timeout", 0, 1);
    end
    valid_i = 1'b0;
    repeat (W + 4) step();
    data_i = 8'h03;
    valid_i = 1'b1;
    step();
    data_i = 8'h04;
    sv_cnt = 0;
    rdy_cnt = 0;
    repeat (W + 3) step();
    valid_i = 1'b0;
    repeat (W + 3) step();
    chk("b2b_valid_cycles", sv_cnt, 22);
    chk("b2b_ready_cycles", rdy_cnt, 2);
    data_i = 8'hA5;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (3) step();
    chk("busy_ready", ready_o, 0);
    data_i = 8'h5A;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (W + 4) step();
    chk("ignored_pulse_val", last_val, 8'hA5 * 8 + check_word(8'hA5));
    data_i = 8'hC3;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (4) step();
    do_reset();
    repeat (2) step();
    single(8'h2B, 8'h2B * 8 + check_word(8'h2B));
    for (int i = 0; i < 400; i++) begin
      valid_i = $urandom_range(0, 3) != 0;
      data_i = W'($urandom);
      step();
    end
    valid_i = 1'b0;
    repeat (W + 4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
